reg_bank_arbiter: RTL and testbench
===================================

# reg_bank_arbiter

Shares one bank of `memory_reg`-style parameter registers (FAST threshold, arc length, border margin, orientation patch radius) between several pipeline clients: the host configuration port, the FAST scorer and the orientation unit. It arbitrates requests round-robin, performs one read or write per grant, and drives per-register `load_enable` and a shared `parallel_in` into the bank. It reads the bank back through the concatenated `parallel_out` bus.

## Interface
Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- NUM_REGS, 8, registers in bank
- DATA_W, 8, register width
- ADDR_W, 3, address width; must satisfy 2^ADDR_W >= NUM_REGS

Ports:
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data
- req_ready  out  NUM_REQ  one-hot accept strobe
- rsp_valid  out  NUM_REQ  one-hot response strobe
- rsp_rdata  out  DATA_W  read data, shared by all requesters
- load_enable  out  NUM_REGS  one-hot register write strobe
- parallel_in  out  DATA_W  write data to bank
- bank_rdata  in  NUM_REGS*DATA_W  concatenated register outputs, reg j at [j*DATA_W +: DATA_W]

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any req_valid is set, the winner is chosen round-robin starting at rr_ptr. Register the winner index, write bit, address and wdata; go to ACCESS. With no request, stay in IDLE.
- ACCESS: req_ready[winner]=1.
  - Write: load_enable[addr]=1 and parallel_in=latched wdata.
  - Read: capture bank_rdata slice into rdata register.
  - Always go to RESP.
- RESP: rsp_valid[winner]=1 and rsp_rdata=captured data. For a write, rsp_rdata=0. Set rr_ptr to (winner+1) mod NUM_REQ and go to IDLE.
- Requesters hold req_valid/addr/wdata stable until req_ready. The block uses only values latched in IDLE, so a requester that drops valid early still gets its transaction completed.
- Out-of-range address (addr >= NUM_REGS): no load_enable is asserted, read data is 0, and the response is still issued.
- At most one bit of req_ready, rsp_valid and load_enable is set in any cycle.
- parallel_in = 0 whenever load_enable is all-zero.

## Timing
- Reset values:
  - state IDLE, rr_ptr 0, latched fields 0.
  - All outputs 0: req_ready, rsp_valid, rsp_rdata, load_enable, parallel_in.
- Outputs are decoded from registered state and latched fields only. There is no combinational path from req_* to any output.
- Per transaction: valid seen in IDLE at cycle 0; ready and load_enable in cycle 1; rsp_valid in cycle 2; the bank register holds new data from cycle 2. The next grant is decided in cycle 3. Peak throughput is one access per 3 cycles.
- A read captures the pre-edge value in ACCESS. A write followed by a read of the same register by another requester returns the new value.
- Reset asserted mid-transaction aborts it: no load_enable pulse after n_rst falls and no pending response. The requester must reissue.

## Configuration
- REG_BANK_ARB_ERR_EN defined: adds output rsp_err (1 bit, reset 0).
  - rsp_err is asserted with rsp_valid when the latched addr >= NUM_REGS.
  - A write to register 0 (the lock register) from any requester other than index 0 is dropped and flagged as an error.
- Not defined: no rsp_err port, and any requester may write any in-range register.

## Structure
- Package reg_bank_pkg holds:
  - state_t enum {IDLE, ACCESS, RESP}
  - default localparams DATA_W_DEF=8, NUM_REGS_DEF=8
  - LOCK_REG_ADDR=0
- Sub-module rr_arbiter_pick: combinational round-robin picker. Inputs are the request vector and rr_ptr; outputs are winner index and any_req. It is instantiated once.

## Test plan
- Single write: req 1 writes addr 2 = 0x5A → load_enable=8'b0000_0100 for exactly 1 cycle, parallel_in=0x5A, rsp_valid[1] one cycle later, rsp_rdata=0.
- Read back: bank reg 2 = 0x5A, req 0 reads addr 2 → rsp_valid[0] at cycle +2, rsp_rdata=0x5A.
- Fairness: all 3 requesters held valid continuously → grant order 0,1,2,0,1,2, each spaced 3 cycles, no starvation.
- Out-of-range: NUM_REGS=6, write addr 7 → no load_enable bit set, response still issued. With REG_BANK_ARB_ERR_EN defined, rsp_err=1.
- Lock (REG_BANK_ARB_ERR_EN defined): req 2 writes addr 0 → dropped, rsp_err=1. Req 0 writing addr 0 succeeds.
- Reset in ACCESS: assert n_rst during write grant → load_enable drops immediately, no rsp_valid, rr_ptr=0 after release.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared types and defaults for the parameter register bank arbiter.
// Used by reg_bank_arbiter and rr_arbiter_pick.
package reg_bank_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam int DATA_W_DEF    = 8;
  localparam int NUM_REGS_DEF  = 8;
  localparam int LOCK_REG_ADDR = 0;

endpackage

// File: rtl/reg_bank_arbiter_pick.sv
// Combinational round-robin picker: first set request at or after ptr.
// Instantiated once by reg_bank_arbiter.
module rr_arbiter_pick #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               any_req
);

  always_comb begin
    int s;
    logic [IDX_W-1:0] idx;
    s       = 0;
    idx     = '0;
    winner  = '0;
    any_req = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      s = int'(ptr) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      idx = IDX_W'(s);
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        winner  = idx;
      end
    end
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin shared access to the parameter register bank.
// REG_BANK_ARB_ERR_EN adds rsp_err and the register-0 write lock.
module reg_bank_arbiter
  import reg_bank_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = 3
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic [NUM_REGS-1:0]        load_enable,
  output logic [DATA_W-1:0]          parallel_in,
  input  logic [NUM_REGS*DATA_W-1:0] bank_rdata
`ifdef REG_BANK_ARB_ERR_EN
  ,
  output logic                       rsp_err
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    win_q, win_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [IDX_W-1:0]    pick;
  logic                any_req;
  logic                in_range;
  logic                lock_blk;

  rr_arbiter_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req     (req_valid),
    .ptr     (ptr_q),
    .winner  (pick),
    .any_req (any_req)
  );

  assign in_range = int'(addr_q) < NUM_REGS;

`ifdef REG_BANK_ARB_ERR_EN
  // Only requester 0 (host port) may write the lock register.
  assign lock_blk = wr_q && (int'(addr_q) == LOCK_REG_ADDR)
                    && (win_q != '0);
  assign rsp_err  = (state_q == RESP) && (!in_range || lock_blk);
`else
  assign lock_blk = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    req_ready   = '0;
    rsp_valid   = '0;
    rsp_rdata   = '0;
    load_enable = '0;
    parallel_in = '0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = ACCESS;
          win_d   = pick;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (pick == IDX_W'(i)) begin
              wr_d    = req_write[i];
              addr_d  = req_addr[i*ADDR_W +: ADDR_W];
              wdata_d = req_wdata[i*DATA_W +: DATA_W];
            end
          end
        end
      end
      ACCESS: begin
        state_d          = RESP;
        req_ready[win_q] = 1'b1;
        rdata_d          = '0;
        if (wr_q) begin
          if (in_range && !lock_blk) begin
            load_enable = NUM_REGS'(1) << addr_q;
            parallel_in = wdata_q;
          end
        end else begin
          for (int j = 0; j < NUM_REGS; j++) begin
            if (addr_q == ADDR_W'(j))
              rdata_d = bank_rdata[j*DATA_W +: DATA_W];
          end
        end
      end
      RESP: begin
        state_d          = IDLE;
        rsp_valid[win_q] = 1'b1;
        rsp_rdata        = rdata_q;
        if (win_q == IDX_W'(NUM_REQ - 1)) ptr_d = '0;
        else ptr_d = win_q + IDX_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Scoreboard bench for reg_bank_arbiter with a behavioural register bank.
// Build with +define+REG_BANK_ARB_ERR_EN to cover rsp_err and the lock.
module tb_reg_bank_arbiter;

  localparam int NREQ  = 3;
  localparam int NREGS = 6;
  localparam int DW    = 8;
  localparam int AW    = 3;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_write = '0;
  logic [NREQ*AW-1:0]  req_addr = '0;
  logic [NREQ*DW-1:0]  req_wdata = '0;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ-1:0]     rsp_valid;
  logic [DW-1:0]       rsp_rdata;
  logic [NREGS-1:0]    load_enable;
  logic [DW-1:0]       parallel_in;
  logic [NREGS*DW-1:0] bank_rdata;
`ifdef REG_BANK_ARB_ERR_EN
  logic                rsp_err;
`endif

  reg_bank_arbiter #(
    .NUM_REQ  (NREQ),
    .NUM_REGS (NREGS),
    .DATA_W   (DW),
    .ADDR_W   (AW)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .req_valid   (req_valid),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .load_enable (load_enable),
    .parallel_in (parallel_in),
    .bank_rdata  (bank_rdata)
`ifdef REG_BANK_ARB_ERR_EN
    ,
    .rsp_err     (rsp_err)
`endif
  );

  // Behavioural memory_reg bank
  logic [DW-1:0] bank [NREGS];
  logic bank_init = 1'b1;
  always @(posedge clk) begin
    for (int j = 0; j < NREGS; j++) begin
      if (bank_init) bank[j] <= DW'(8'hA0 + j);
      else if (load_enable[j]) bank[j] <= parallel_in;
    end
  end
  for (genvar j = 0; j < NREGS; j++) begin : g_bank
    assign bank_rdata[j*DW +: DW] = bank[j];
  end

  typedef struct {
    int          idx;
    logic [DW-1:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int passed = 0;

  function automatic exp_t mk(int idx, logic [DW-1:0] rd, logic err);
    exp_t e;
    e.idx = idx;
    e.rdata = rd;
    e.err = err;
    return e;
  endfunction

  // Response monitor: pops the scoreboard on every response
  always @(negedge clk) begin
    if (n_rst && rsp_valid != '0) begin
      exp_t e;
      total++;
      if (sb.size() == 0) begin
        $display("FAIL rsp_unexpected: rsp_valid=%b with empty scoreboard",
                 rsp_valid);
      end else begin
        e = sb.pop_front();
        if (rsp_valid !== NREQ'(1 << e.idx) || rsp_rdata !== e.rdata)
          $display("FAIL rsp: got valid=%b rdata=%h, want valid=%b rdata=%h",
                   rsp_valid, rsp_rdata, NREQ'(1 << e.idx), e.rdata);
        else passed++;
`ifdef REG_BANK_ARB_ERR_EN
        total++;
        if (rsp_err !== e.err)
          $display("FAIL rsp_err: got %b want %b", rsp_err, e.err);
        else passed++;
`endif
      end
    end
  end

  // One-hot and idle-bus invariants
  always @(negedge clk) begin
    if (n_rst) begin
      total++;
      if ($countones(req_ready) > 1 || $countones(rsp_valid) > 1 ||
          $countones(load_enable) > 1 ||
          (load_enable == '0 && parallel_in != '0))
        $display("FAIL onehot: ready=%b rsp=%b le=%b pin=%h want one-hot",
                 req_ready, rsp_valid, load_enable, parallel_in);
      else passed++;
    end
  end

  task automatic do_req(input int i, input bit wr, input int addr,
                        input logic [DW-1:0] wd);
    logic [NREGS-1:0] exp_le;
    bit blk;
    int n;
    req_valid[i] = 1'b1;
    req_write[i] = wr;
    req_addr[i*AW +: AW] = AW'(addr);
    req_wdata[i*DW +: DW] = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[i] && n < 40);
    if (!req_ready[i]) begin
      total++;
      $display("FAIL ready_timeout req%0d: ready=%b want bit set", i,
               req_ready);
      req_valid[i] = 1'b0;
      return;
    end
    blk = 1'b0;
`ifdef REG_BANK_ARB_ERR_EN
    blk = (addr == 0 && i != 0);
`endif
    exp_le = '0;
    if (wr && addr < NREGS && !blk) exp_le[addr] = 1'b1;
    total++;
    if (load_enable !== exp_le ||
        parallel_in !== ((exp_le != '0) ? wd : '0))
      $display("FAIL access req%0d: le=%b pin=%h want le=%b pin=%h", i,
               load_enable, parallel_in, exp_le,
               (exp_le != '0) ? wd : '0);
    else passed++;
    req_valid[i] = 1'b0;
    @(negedge clk);
    total++;
    if (rsp_valid !== NREQ'(1 << i) || load_enable !== '0)
      $display("FAIL rsp_timing req%0d: rsp=%b le=%b want rsp=%b le=0", i,
               rsp_valid, load_enable, NREQ'(1 << i));
    else passed++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic test_reset();
    bank_init = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (req_ready !== '0 || rsp_valid !== '0 || rsp_rdata !== '0 ||
        load_enable !== '0 || parallel_in !== '0)
      $display("FAIL reset_outputs: ready=%b rsp=%b rd=%h le=%b pin=%h want 0",
               req_ready, rsp_valid, rsp_rdata, load_enable, parallel_in);
    else passed++;
`ifdef REG_BANK_ARB_ERR_EN
    total++;
    if (rsp_err !== 1'b0) $display("FAIL reset_err: got %b want 0", rsp_err);
    else passed++;
`endif
    n_rst = 1'b1;
    bank_init = 1'b0;
  endtask

  task automatic test_single_write();
    sb.push_back(mk(1, '0, 1'b0));
    do_req(1, 1'b1, 2, 8'h5A);
    total++;
    if (bank[2] !== 8'h5A)
      $display("FAIL write_bank: reg2=%h want 5a", bank[2]);
    else passed++;
  endtask

  task automatic test_read_back();
    sb.push_back(mk(0, 8'h5A, 1'b0));
    do_req(0, 1'b0, 2, '0);
  endtask

  task automatic test_out_of_range();
    logic [DW-1:0] snap [NREGS];
    for (int j = 0; j < NREGS; j++) snap[j] = bank[j];
    sb.push_back(mk(0, '0, 1'b1));
    do_req(0, 1'b1, 7, 8'hEE);
    total++;
    if (bank !== snap) $display("FAIL oor_write: bank changed, want unchanged");
    else passed++;
    sb.push_back(mk(2, '0, 1'b1));
    do_req(2, 1'b0, 6, '0);
  endtask

  task automatic test_lock();
`ifdef REG_BANK_ARB_ERR_EN
    logic [DW-1:0] old0;
    old0 = bank[0];
    sb.push_back(mk(2, '0, 1'b1));
    do_req(2, 1'b1, 0, 8'h33);
    total++;
    if (bank[0] !== old0)
      $display("FAIL lock_drop: reg0=%h want %h", bank[0], old0);
    else passed++;
    sb.push_back(mk(0, '0, 1'b0));
    do_req(0, 1'b1, 0, 8'h44);
    total++;
    if (bank[0] !== 8'h44) $display("FAIL lock_host: reg0=%h want 44", bank[0]);
    else passed++;
`else
    sb.push_back(mk(2, '0, 1'b0));
    do_req(2, 1'b1, 0, 8'h33);
    total++;
    if (bank[0] !== 8'h33) $display("FAIL reg0_write: reg0=%h want 33", bank[0]);
    else passed++;
`endif
  endtask

  task automatic test_back_to_back();
    do_reset();
    sb.push_back(mk(1, '0, 1'b0));
    sb.push_back(mk(2, 8'h77, 1'b0));
    fork
      do_req(1, 1'b1, 3, 8'h77);
      do_req(2, 1'b0, 3, '0);
    join
  endtask

  task automatic test_fairness();
    int gidx[$];
    int gcyc[$];
    int cyc;
    do_reset();
    for (int k = 0; k < 6; k++) sb.push_back(mk(k % 3, bank[k % 3], 1'b0));
    for (int i = 0; i < NREQ; i++) begin
      req_write[i] = 1'b0;
      req_addr[i*AW +: AW] = AW'(i);
    end
    req_valid = '1;
    cyc = 0;
    while (gidx.size() < 6 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < NREQ; i++)
        if (req_ready[i]) begin
          gidx.push_back(i);
          gcyc.push_back(cyc);
        end
    end
    req_valid = '0;
    total++;
    if (gidx.size() != 6)
      $display("FAIL fair_count: grants=%0d want 6", gidx.size());
    else passed++;
    for (int g = 0; g < gidx.size(); g++) begin
      total++;
      if (gidx[g] != g % 3 || (g > 0 && gcyc[g] - gcyc[g-1] != 3))
        $display("FAIL fair_order g%0d: idx=%0d gap=%0d want idx=%0d gap=3",
                 g, gidx[g], (g > 0) ? gcyc[g] - gcyc[g-1] : 3, g % 3);
      else passed++;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_access();
    logic [DW-1:0] old4;
    int n;
    sb.push_back(mk(0, '0, 1'b0));
    do_req(0, 1'b1, 5, 8'h21);
    @(negedge clk);
    old4 = bank[4];
    req_valid[2] = 1'b1;
    req_write[2] = 1'b1;
    req_addr[2*AW +: AW] = AW'(4);
    req_wdata[2*DW +: DW] = 8'h99;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[2] && n < 20);
    total++;
    if (load_enable !== NREGS'(6'b010000))
      $display("FAIL abort_grant: le=%b want 010000", load_enable);
    else passed++;
    #2 n_rst = 1'b0;
    #1;
    total++;
    if (load_enable !== '0 || req_ready !== '0 || parallel_in !== '0)
      $display("FAIL abort_drop: le=%b ready=%b pin=%h want 0", load_enable,
               req_ready, parallel_in);
    else passed++;
    req_valid = '0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (rsp_valid !== '0)
        $display("FAIL abort_rsp: rsp=%b want 0", rsp_valid);
      else passed++;
    end
    total++;
    if (bank[4] !== old4)
      $display("FAIL abort_bank: reg4=%h want %h", bank[4], old4);
    else passed++;
    // ptr back to 0: requester 0 must beat requester 2
    sb.push_back(mk(0, bank[1], 1'b0));
    sb.push_back(mk(2, '0, 1'b0));
    fork
      do_req(0, 1'b0, 1, '0);
      do_req(2, 1'b1, 5, 8'h55);
    join
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_back();
    test_out_of_range();
    test_lock();
    test_back_to_back();
    test_fairness();
    test_reset_access();
    repeat (3) @(negedge clk);
    total++;
    if (sb.size() != 0)
      $display("FAIL sb_drain: %0d responses outstanding, want 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
